nto1_arb_mux: RTL
=================

Name: nto1_arb_mux

Overview:
- Registered, parametrised N-to-1 multiplexer with per-channel valid/ready handshakes and selectable arbitration mode.
- Mode FIXED forwards the channel named by `sel`.
- Mode RR round-robins fairly across all requesting channels.
- Used wherever several producers share one downstream consumer. Output is a single registered stage, so the consumer sees a registered interface.

Parameters:
- N, 4, number of input channels; legal range N >= 2.
- W, 8, data width per channel in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ip  input  [N-1:0][W-1:0]  packed channel data; channel i is ip[i].
- ip_valid  input  N  per-channel request; bit i qualifies ip[i].
- ip_ready  output  N  per-channel accept; combinational, one-hot or zero.
- mode  input  1  0 = MODE_FIXED, 1 = MODE_RR.
- sel  input  $clog2(N)  channel select, used only in MODE_FIXED.
- out  output  W  registered output data.
- out_valid  output  1  out holds a valid beat.
- out_ready  input  1  downstream accepts the beat.
- out_sel  output  $clog2(N)  index of the channel that produced out.

Behaviour:
- Reset (rst=1 at a rising edge):
  - out = 0, out_valid = 0, out_sel = 0.
  - RR pointer last_grant = N-1, so channel 0 has first RR priority.
  - ip_ready is 0 during any cycle in which rst=1.
  - Reset mid-transfer drops the held beat with no output.
- Output stage holds one beat.
  - load_en = !out_valid || out_ready.
  - Downstream transfer happens when out_valid && out_ready.
- Grant (combinational, evaluated only when load_en=1):
  - MODE_FIXED: grant[sel] = ip_valid[sel]. If sel >= N (possible when N is not a power of 2), no grant.
  - MODE_RR: grant the first i with ip_valid[i] set, searching from last_grant+1 upward modulo N, including last_grant itself last.
  - No valid request means no grant.
- ip_ready = grant when load_en=1, else 0. A handshake on channel i is ip_valid[i] && ip_ready[i].
- On a rising edge with load_en=1:
  - If any grant: out <= ip[g], out_sel <= g, out_valid <= 1.
  - If no grant: out_valid <= 0; out and out_sel hold their values.
- On a rising edge with load_en=0: all output registers hold.
- Latency: a beat accepted at edge k appears with out_valid=1 after edge k.
- Throughput: one beat per cycle when out_ready stays high.
- Simultaneous events:
  - An output drain and a new accept in the same cycle are legal; the new beat replaces the old.
  - Stalled backpressure (out_valid=1, out_ready=0): out, out_sel and out_valid are stable, and all ip_ready bits are 0.
- last_grant updates to g only on an input handshake in MODE_RR. It is unchanged in MODE_FIXED.
- Switching mode mid-stream takes effect on the next grant evaluation. The held beat is unaffected.
- Inputs are sampled only on a handshake. Changing ip or sel while not granted has no effect.

Decomposition:
- Package nto1_mux_pkg:
  - typedef enum logic {MODE_FIXED=1'b0, MODE_RR=1'b1} mux_mode_e.
  - Helper function next_idx(idx, n) for modulo-N increment.
- One sub-module, rr_arbiter #(N):
  - Inputs: clk, rst, req[N], advance.
  - Outputs: grant[N] one-hot.
  - Owns last_grant. Top level uses it in MODE_RR and advances it on a handshake.
- Top level owns the fixed-select path, the output register and the ready logic.

Test Plan (N=4, W=8 unless stated):
- Reset: hold rst=1 for 2 cycles with all ip_valid=1 -> ip_ready=0, out_valid=0, out=0x00 throughout; after release, RR first grants channel 0.
- FIXED pass-through: mode=0, sel=2, ip[2]=0xA5, ip_valid=4'b1111, out_ready=1 -> ip_ready=4'b0100; next cycle out=0xA5, out_sel=2, out_valid=1.
- RR fairness: mode=1, ip_valid=4'b1111 for 8 cycles, out_ready=1 -> out_sel sequence 0,1,2,3,0,1,2,3; a sparse ip_valid=4'b1010 gives 1,3,1,3.
- Backpressure: out_valid=1 with out=0x3C, then out_ready=0 for 3 cycles -> out stays 0x3C, ip_ready=0, last_grant unchanged; out_ready=1 drains 0x3C and accepts the next beat in the same cycle.
- Idle/out-of-range: N=3, mode=0, sel=3, ip_valid=3'b111 -> no grant, ip_ready=0, out_valid drops to 0 after the prior beat drains.
- Reset mid-stream: rst=1 while out_valid=1 -> out_valid=0 next cycle, beat discarded, RR restarts at channel 0.

Source files
------------

// File: rtl/nto1_mux_pkg.sv
// nto1_mux_pkg: shared types and helpers for the N-to-1 arbitrating mux.
// Provides the mode enum and a modulo-N index increment.
package nto1_mux_pkg;

   typedef enum logic {
      MODE_FIXED = 1'b0,
      MODE_RR    = 1'b1
   } mux_mode_e;

   function automatic int unsigned next_idx(
      input int unsigned idx,
      input int unsigned n
   );
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/nto1_arb_mux_rr_arbiter.sv
// rr_arbiter: round-robin arbiter owning last_grant (reset to N-1).
// Ports: clk, rst, req[N], advance (commit current grant) -> grant[N] one-hot.
module rr_arbiter
   import nto1_mux_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);

   localparam int SW = $clog2(N);

   logic [SW-1:0] last_grant;
   int unsigned   idx;
   int unsigned   gidx;
   logic          found;

   // Search starts just past last_grant and visits last_grant itself last.
   always_comb begin
      grant = '0;
      found = 1'b0;
      gidx  = 0;
      idx   = 32'(last_grant);
      for (int k = 0; k < N; k++) begin
         idx = next_idx(idx, N);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            gidx       = idx;
            found      = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= SW'(N - 1);
      end else if (advance && found) begin
         last_grant <= SW'(gidx);
      end
   end

endmodule

// File: rtl/nto1_arb_mux.sv
// nto1_arb_mux: registered N-to-1 mux, fixed-select or round-robin arbitration.
// Ports: ip/ip_valid/ip_ready per channel, mode, sel -> out/out_valid/out_ready/out_sel.
module nto1_arb_mux
   import nto1_mux_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0][W-1:0]  ip,
   input  logic [N-1:0]         ip_valid,
   output logic [N-1:0]         ip_ready,
   input  logic                 mode,
   input  logic [$clog2(N)-1:0] sel,
   output logic [W-1:0]         out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [$clog2(N)-1:0] out_sel
);

   localparam int SW = $clog2(N);

   logic          load_en;
   logic          is_rr;
   logic [N-1:0]  fixed_grant;
   logic [N-1:0]  rr_grant;
   logic [N-1:0]  grant;
   logic [SW-1:0] gidx;
   logic          rr_advance;

   assign is_rr   = (mode == MODE_RR);
   assign load_en = !out_valid || out_ready;

   // sel can exceed N-1 when N is not a power of two; that grants nothing.
   always_comb begin
      fixed_grant = '0;
      if (int'(sel) < N) begin
         fixed_grant[sel] = ip_valid[sel];
      end
   end

   rr_arbiter #(
      .N (N)
   ) u_rr (
      .clk     (clk),
      .rst     (rst),
      .req     (ip_valid),
      .advance (rr_advance),
      .grant   (rr_grant)
   );

   // Grants only count when the output stage can take a beat and not in reset.
   assign grant    = (is_rr ? rr_grant : fixed_grant)
                   & {N{load_en && !rst}};
   assign ip_ready = grant;

   assign rr_advance = is_rr && |(ip_valid & ip_ready);

   always_comb begin
      gidx = '0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) begin
            gidx = SW'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out       <= '0;
         out_valid <= 1'b0;
         out_sel   <= '0;
      end else if (load_en) begin
         if (|grant) begin
            out       <= ip[gidx];
            out_sel   <= gidx;
            out_valid <= 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
